// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: SHW-stage pipelined barrel shifter (SLL/SRL/SRA/ROR)
// with carry-out and a valid/ready handshake carrying full backpressure.
module shift_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    logic [SHW-1:0]   valid_q;
    logic [SHW-1:0]   valid_d;
    logic [SHW-1:0]   carry_q;
    logic [SHW-1:0]   carry_d;
    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [1:0]       mode_q  [SHW];
    logic [1:0]       mode_d  [SHW];
    logic [SHW-1:0]   shift_q [SHW];
    logic [SHW-1:0]   shift_d [SHW];

    logic [SHW-1:0]   load;
    logic [SHW-1:0]   src_valid;
    logic [SHW-1:0]   src_carry;
    logic [WIDTH-1:0] src_data  [SHW];
    logic [1:0]       src_mode  [SHW];
    logic [SHW-1:0]   src_shift [SHW];

    // One stage's fixed shift by 2^k; returns {carry, data}.
    function automatic logic [WIDTH:0] stage_op(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int unsigned      k
    );
        int unsigned      a;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] t;
        a = 1 << k;
        unique case (m)
            2'b00: begin
                r = d << a;
                t = d >> (WIDTH - a);
            end
            2'b01: begin
                r = d >> a;
                t = d >> (a - 1);
            end
            2'b10: begin
                r = WIDTH'($signed(d) >>> a);
                t = d >> (a - 1);
            end
            default: begin
                r = (d >> a) | (d << (WIDTH - a));
                t = d >> (a - 1);
            end
        endcase
        return {t[0], r};
    endfunction

    // Stage k may load if out_ready or any stage from k onward is empty.
    always_comb begin
        load = '0;
        for (int k = 0; k < SHW; k++) begin
            load[k] = out_ready |
                      ~(&(valid_q | SHW'((1 << k) - 1)));
        end
    end

    assign in_ready = rst_n & load[0];

    always_comb begin
        src_valid    = '0;
        src_carry    = '0;
        src_valid[0] = in_valid & in_ready;
        src_data[0]  = in_data;
        src_mode[0]  = in_mode;
        src_shift[0] = in_shift;
        for (int k = 1; k < SHW; k++) begin
            src_valid[k] = valid_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_data[k]  = data_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_shift[k] = shift_q[k-1];
        end
    end

    always_comb begin
        logic [WIDTH:0] op;
        logic           do_shift;
        valid_d = valid_q;
        carry_d = carry_q;
        for (int k = 0; k < SHW; k++) begin
            data_d[k]  = data_q[k];
            mode_d[k]  = mode_q[k];
            shift_d[k] = shift_q[k];
            op         = stage_op(src_data[k], src_mode[k], k);
            do_shift   = |(src_shift[k] & SHW'(1 << k));
            if (load[k]) begin
                valid_d[k] = src_valid[k];
            end
            if (load[k] && src_valid[k]) begin
                data_d[k]  = do_shift ? op[WIDTH-1:0] : src_data[k];
                carry_d[k] = do_shift ? op[WIDTH] : src_carry[k];
                mode_d[k]  = src_mode[k];
                shift_d[k] = src_shift[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= '0;
                mode_q[k]  <= '0;
                shift_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= data_d[k];
                mode_q[k]  <= mode_d[k];
                shift_q[k] <= shift_d[k];
            end
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_carry = carry_q[SHW-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed shifts, streaming,
// backpressure and mid-flight reset.
module tb_shift_unit_pipe;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [S-1:0] in_shift;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_carry;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;
    bit lat_mode = 1'b1;

    typedef struct {
        logic [W:0] exp;
        int         acc;
        bit         lat;
    } sb_t;
    sb_t q[$];

    typedef struct {
        logic [1:0]  m;
        logic [W-1:0] d;
        int          s;
        logic [W:0]  e;
    } vec_t;

    vec_t dir [11] = '{
        '{2'd2, 16'h8001,  1, 17'h1C000},
        '{2'd2, 16'h8000, 15, 17'h0FFFF},
        '{2'd0, 16'hC000,  1, 17'h18000},
        '{2'd1, 16'hF000, 12, 17'h0000F},
        '{2'd1, 16'h0008,  4, 17'h10000},
        '{2'd3, 16'h1234,  4, 17'h04123},
        '{2'd3, 16'h0001,  1, 17'h18000},
        '{2'd0, 16'hA5C3,  0, 17'h0A5C3},
        '{2'd1, 16'hA5C3,  0, 17'h0A5C3},
        '{2'd2, 16'hA5C3,  0, 17'h0A5C3},
        '{2'd3, 16'hA5C3,  0, 17'h0A5C3}
    };

    shift_unit_pipe #(.WIDTH(W), .SHW(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shift (in_shift),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_op(logic [1:0] m, logic [W-1:0] d,
                                          int s);
        logic [W-1:0] r;
        logic [W-1:0] t;
        case (m)
            2'd0: begin
                r = d << s;
                t = d >> (W - s);
            end
            2'd1: begin
                r = d >> s;
                t = d >> (s - 1);
            end
            2'd2: begin
                r = W'($signed(d) >>> s);
                t = d >> (s - 1);
            end
            default: begin
                r = (d >> s) | (d << (W - s));
                t = r >> (W - 1);
            end
        endcase
        return {(s != 0) ? t[0] : 1'b0, r};
    endfunction

    always @(negedge clk) begin : mon
        sb_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("out_data", 32'(out_data), 32'(e.exp[W-1:0]));
                check("out_carry", 32'(out_carry), 32'(e.exp[W]));
                if (e.lat) check("latency", cyc - e.acc, 32'd3);
            end
        end
    end

    task automatic drive(logic [1:0] m, logic [W-1:0] d, int s);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_shift = S'(s);
    endtask

    task automatic wait_acc(logic [W:0] exp);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{exp, cyc + 1, lat_mode});
                return;
            end
            stalls++;
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(logic [1:0] m, logic [W-1:0] d, int s,
                        logic [W:0] exp);
        @(posedge clk);
        #1;
        drive(m, d, s);
        wait_acc(exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", q.size(), 32'd0);
    endtask

    initial begin
        logic [1:0]   m;
        logic [W-1:0] d;
        int           s;
        int           acc;
        bit           held;
        logic [W:0]   hold_v;
        vec_t         bp [6];

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rdy_after_rst", 32'(in_ready), 32'd1);

        // directed vectors, one at a time
        foreach (dir[i]) begin
            send(dir[i].m, dir[i].d, dir[i].s, dir[i].e);
            idle();
            drain();
        end

        // streaming, 8 back-to-back ops
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            m = 2'($urandom_range(0, 3));
            d = W'($urandom);
            s = $urandom_range(0, W - 1);
            send(m, d, s, ref_op(m, d, s));
        end
        idle();
        check("stream_stalls", stalls, 32'd0);
        drain();

        // backpressure: out_ready low for 6 cycles
        lat_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bp[i].m = 2'($urandom_range(0, 3));
            bp[i].d = W'($urandom);
            bp[i].s = $urandom_range(0, W - 1);
        end
        acc  = 0;
        held = 1'b0;
        hold_v = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            drive(bp[acc].m, bp[acc].d, bp[acc].s);
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{ref_op(bp[acc].m, bp[acc].d, bp[acc].s),
                              cyc + 1, 1'b0});
                acc++;
            end
            if (out_valid) begin
                if (!held) begin
                    held   = 1'b1;
                    hold_v = {out_carry, out_data};
                end else begin
                    check("stall_stable", 32'({out_carry, out_data}),
                          32'(hold_v));
                end
            end
        end
        check("bp_accepted", acc, 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_acc(ref_op(in_mode, in_data, int'(in_shift)));
        for (int i = acc + 1; i < 6; i++) begin
            send(bp[i].m, bp[i].d, bp[i].s,
                 ref_op(bp[i].m, bp[i].d, bp[i].s));
        end
        idle();
        drain();
        lat_mode = 1'b1;

        // reset with 3 ops in flight
        for (int i = 0; i < 3; i++) begin
            send(2'd0, W'(16'h0101 << i), i + 1,
                 ref_op(2'd0, W'(16'h0101 << i), i + 1));
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_carry", 32'(out_carry), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        q.delete();
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        send(2'd3, 16'h1234, 4, 17'h04123);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
